alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result width in bits (legal 4..16).
REQ-002 SHALL provide port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: start  in  1  request pulse; operands and enables sampled on the edge where start=1 and unit is idle.
REQ-005 SHALL provide port: enables  in  7  one-hot op select from the decoder: bit6 xor, bit5 add, bit4 sub, bit3 and, bit2 or, bit1 divide, bit0 modulo.
REQ-006 SHALL provide port: a  in  WIDTH  operand A (dividend for divide/modulo).
REQ-007 SHALL provide port: b  in  WIDTH  operand B (divisor for divide/modulo).
REQ-008 SHALL provide port: result  out  WIDTH  registered result, held until next done.
REQ-009 SHALL provide port: carry  out  1  add carry-out / sub borrow; 0 for other ops.
REQ-010 SHALL provide port: err  out  1  error flag, valid with done, held until next done.
REQ-011 SHALL provide port: busy  out  1  high while an iterative divide/modulo is in progress.
REQ-012 SHALL provide port: done  out  1  one-cycle pulse marking result/carry/err valid.

Function
REQ-013 SHALL implement FSM states IDLE, DIV, FIN; IDLE->DIV on accepted divide/modulo start with b!=0; DIV->FIN after WIDTH iterations; FIN->IDLE unconditionally.
REQ-014 SHALL complete xor/add/sub/and/or in 1 cycle: done=1 the cycle after start, busy never asserted, FSM stays IDLE.
REQ-015 SHALL compute add/sub modulo 2^WIDTH; carry = bit WIDTH of a+b for add, carry = (a<b) for sub.
REQ-016 SHALL compute divide/modulo by restoring shift-subtract, one quotient bit per cycle, MSB first; divide returns quotient, modulo returns remainder.
REQ-017 SHALL, for divide/modulo, assert busy for exactly WIDTH cycles starting the cycle after start, and pulse done in cycle WIDTH+1 after start with busy=0.
REQ-018 SHALL ignore start while busy=1 or in FIN; operands sampled at acceptance are not affected by later input changes.
REQ-019 SHALL, on divide/modulo with b=0, respond in 1 cycle with err=1; result = all ones for divide, result = a for modulo.
REQ-020 SHALL, when enables is not exactly one-hot (zero or multiple bits), respond in 1 cycle with err=1, result=0, carry=0.
REQ-021 SHALL clear err on every error-free done.
REQ-022 SHALL accept a new start in the same cycle done is pulsed for a 1-cycle op (back-to-back throughput 1/cycle); for divide/modulo the earliest new accept is the done (FIN) cycle+1.

Reset
REQ-023 SHALL on rst_n=0 immediately force FSM=IDLE, result=0, carry=0, err=0, busy=0, done=0, clearing divider registers.
REQ-024 SHALL abort an in-progress division on reset with no done pulse; first start after rst_n release is accepted normally.

Configuration
REQ-025 SHALL gate the iterative divider with macro ALU_EXEC_DIV_EN: defined -> REQ-013/016/017/019 apply; undefined -> no divider logic, FSM stays IDLE, busy tied 0, enables bit1/bit0 treated as unsupported: 1-cycle done with err=1, result=0.

Verification
REQ-026 SHALL cover: WIDTH=8, start, enables=0100000, a=200, b=100 -> next cycle done=1, result=44, carry=1, err=0.
REQ-027 SHALL cover: enables=0000010, a=100, b=7 -> busy high 8 cycles, done exactly 9 cycles after start, result=14, err=0; repeat with 0000001 -> result=2.
REQ-028 SHALL cover: enables=0000010, a=5, b=0 -> next cycle done, err=1, result=0xFF; modulo variant -> result=5.
REQ-029 SHALL cover: enables=0110000 and enables=0000000 -> next cycle done, err=1, result=0, carry=0.
REQ-030 SHALL cover: divide 100/7 started, rst_n low at 4th busy cycle -> busy=0, done=0, result=0 asynchronously; after release, add 3+4 -> result=7 next cycle.
REQ-031 SHALL cover: start asserted during divide busy with enables=0100000 -> ignored; only the divide done occurs, result=14.

Source files
------------

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - request/response bundle between the op decoder and alu_exec
`timescale 1ns/1ps
interface alu_exec_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [6:0]       enables;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             err;
  logic             busy;
  logic             done;

  modport master (
    output start, enables, a, b,
    input  result, carry, err, busy, done
  );

  modport slave (
    input  start, enables, a, b,
    output result, carry, err, busy, done
  );
endinterface

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - 1-cycle xor/add/sub/and/or plus iterative divide/modulo enabled by ALU_EXEC_DIV_EN
`timescale 1ns/1ps
module alu_exec #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_exec_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             accept;
  logic             onehot;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // Start is only honoured in IDLE, so requests during DIV/FIN are dropped.
  assign accept = bus.start && (state_q == IDLE);
  assign onehot = (bus.enables != 7'd0) && ((bus.enables & (bus.enables - 7'd1)) == 7'd0);
  assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
  // Top bit of the widened difference is the borrow, i.e. a < b.
  assign diff   = {1'b0, bus.a} - {1'b0, bus.b};

`ifdef ALU_EXEC_DIV_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             mod_q, mod_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_shift;
  logic             q_bit;

  // Restoring step: shift the next dividend bit (MSB first) into the partial remainder.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign q_bit     = (rem_shift >= {1'b0, dvs_q});
  assign bus.busy  = busy_q;
`else
  assign bus.busy  = 1'b0;
`endif

  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.err    = err_q;
  assign bus.done   = done_q;

  // Next-state and next-output logic for the op dispatch and divider FSM.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;
    done_d   = 1'b0;
`ifdef ALU_EXEC_DIV_EN
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    mod_d  = mod_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          done_d   = 1'b1;
          result_d = '0;
          carry_d  = 1'b0;
          err_d    = 1'b0;
          if (!onehot) begin
            err_d = 1'b1;
          end else if (bus.enables[6]) begin
            result_d = bus.a ^ bus.b;
          end else if (bus.enables[5]) begin
            result_d = sum[WIDTH-1:0];
            carry_d  = sum[WIDTH];
          end else if (bus.enables[4]) begin
            result_d = diff[WIDTH-1:0];
            carry_d  = diff[WIDTH];
          end else if (bus.enables[3]) begin
            result_d = bus.a & bus.b;
          end else if (bus.enables[2]) begin
            result_d = bus.a | bus.b;
          end else begin
`ifdef ALU_EXEC_DIV_EN
            if (bus.b == '0) begin
              err_d    = 1'b1;
              result_d = bus.enables[1] ? '1 : bus.a;
            end else begin
              // Iterative path: outputs keep their previous values until the final step.
              done_d   = 1'b0;
              result_d = result_q;
              carry_d  = carry_q;
              err_d    = err_q;
              state_d  = DIV;
              busy_d   = 1'b1;
              quo_d    = bus.a;
              rem_d    = '0;
              dvs_d    = bus.b;
              mod_d    = bus.enables[0];
              cnt_d    = '0;
            end
`else
            err_d = 1'b1;
`endif
          end
        end
      end
      DIV: begin
`ifdef ALU_EXEC_DIV_EN
        quo_d = {quo_q[WIDTH-2:0], q_bit};
        rem_d = q_bit ? WIDTH'(rem_shift - {1'b0, dvs_q}) : rem_shift[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          carry_d  = 1'b0;
          err_d    = 1'b0;
          result_d = mod_q ? rem_d : quo_d;
        end
`else
        state_d = IDLE;
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any division without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      mod_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      done_q   <= done_d;
`ifdef ALU_EXEC_DIV_EN
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      mod_q  <= mod_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard bench for alu_exec (expectations follow ALU_EXEC_DIV_EN)
`timescale 1ns/1ps
module tb_alu_exec;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         e;
    int           cyc;
    int           bsy;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;
  int   c0;
  exp_t q[$];
  exp_t mx;

  alu_exec_if #(.WIDTH(W)) bus();

  alu_exec #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int t);
    while (cyc < t) step();
  endtask

  task automatic stop();
    bus.start = 1'b0;
  endtask

  task automatic drive(input logic [6:0] en, input int av, input int bv, input bit push,
                       input int res, input bit c, input bit e, input int lat, input int bsy);
    exp_t x;
    bus.start   = 1'b1;
    bus.enables = en;
    bus.a       = av[W-1:0];
    bus.b       = bv[W-1:0];
    if (push) begin
      x.res = res[W-1:0];
      x.c   = c;
      x.e   = e;
      x.cyc = cyc + lat;
      x.bsy = bsy;
      q.push_back(x);
    end
  endtask

  // Divide/modulo request: iterative when the divider is built and b != 0, otherwise 1 cycle.
  task automatic drive_div(input logic [6:0] en, input int av, input int bv,
                           input int res, input bit e, input bit slow);
`ifdef ALU_EXEC_DIV_EN
    drive(en, av, bv, 1'b1, res, 1'b0, e, slow ? W + 1 : 1, slow ? W : 0);
`else
    drive(en, av, bv, 1'b1, 0, 1'b0, 1'b1, 1, 0);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    chk("drain_pending", q.size(), 0);
  endtask

  // Monitor: every done pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 result=%0d at cycle %0d expected no done", bus.result, cyc);
        end else begin
          mx = q.pop_front();
          chk("result", int'(bus.result), int'(mx.res));
          chk("carry", int'(bus.carry), int'(mx.c));
          chk("err", int'(bus.err), int'(mx.e));
          chk("done_cycle", cyc, mx.cyc);
          chk("busy_cycles", busy_cnt, mx.bsy);
          chk("busy_at_done", int'(bus.busy), 0);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.enables = 7'd0;
    bus.a       = '0;
    bus.b       = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_result", int'(bus.result), 0);
    chk("rst_carry", int'(bus.carry), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Back-to-back single-cycle ops, illegal selects, then err clearing.
    drive(7'b0100000, 200, 100, 1'b1, 44, 1'b1, 1'b0, 1, 0); step();
    drive(7'b1000000, 240, 60, 1'b1, 204, 1'b0, 1'b0, 1, 0); step();
    drive(7'b0010000, 5, 9, 1'b1, 252, 1'b1, 1'b0, 1, 0); step();
    drive(7'b0010000, 9, 5, 1'b1, 4, 1'b0, 1'b0, 1, 0); step();
    drive(7'b0001000, 240, 60, 1'b1, 48, 1'b0, 1'b0, 1, 0); step();
    drive(7'b0000100, 240, 60, 1'b1, 252, 1'b0, 1'b0, 1, 0); step();
    drive(7'b0100000, 255, 1, 1'b1, 0, 1'b1, 1'b0, 1, 0); step();
    drive(7'b0110000, 7, 9, 1'b1, 0, 1'b0, 1'b1, 1, 0); step();
    drive(7'b0000000, 7, 9, 1'b1, 0, 1'b0, 1'b1, 1, 0); step();
    drive(7'b0100000, 1, 2, 1'b1, 3, 1'b0, 1'b0, 1, 0); step();
    stop();
    drain();

    // Divide / modulo.
    drive_div(7'b0000010, 100, 7, 14, 1'b0, 1'b1); step(); stop(); drain();
    drive_div(7'b0000001, 100, 7, 2, 1'b0, 1'b1); step(); stop(); drain();
    drive_div(7'b0000010, 200, 3, 66, 1'b0, 1'b1); step(); stop(); drain();
    drive_div(7'b0000001, 200, 3, 2, 1'b0, 1'b1); step(); stop(); drain();
    drive_div(7'b0000010, 5, 0, 255, 1'b1, 1'b0); step();
    drive_div(7'b0000001, 5, 0, 5, 1'b1, 1'b0); step();
    drive(7'b0100000, 1, 2, 1'b1, 3, 1'b0, 1'b0, 1, 0); step();
    stop();
    drain();

`ifdef ALU_EXEC_DIV_EN
    // Starts during busy and during the done (FIN) cycle are dropped; the next cycle accepts.
    c0 = cyc;
    drive_div(7'b0000010, 100, 7, 14, 1'b0, 1'b1); step(); stop();
    at(c0 + 3);
    drive(7'b0100000, 1, 1, 1'b0, 0, 1'b0, 1'b0, 0, 0); step(); stop();
    bus.a = 8'd50;
    bus.b = 8'd50;
    at(c0 + W + 1);
    drive(7'b0100000, 1, 1, 1'b0, 0, 1'b0, 1'b0, 0, 0); step();
    drive(7'b0100000, 3, 4, 1'b1, 7, 1'b0, 1'b0, 1, 0); step(); stop();
    drain();

    // Reset in the 4th busy cycle of a division.
    c0 = cyc;
    drive(7'b0000010, 100, 7, 1'b0, 0, 1'b0, 1'b0, 0, 0); step(); stop();
    at(c0 + 4);
    chk("busy_before_rst", int'(bus.busy), 1);
`else
    drive(7'b0100000, 3, 4, 1'b1, 7, 1'b0, 1'b0, 1, 0); step(); stop();
    drain();
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_result", int'(bus.result), 0);
    chk("arst_err", int'(bus.err), 0);
    chk("arst_carry", int'(bus.carry), 0);
    step();
    rst_n = 1'b1;
    step();
    drive(7'b0100000, 3, 4, 1'b1, 7, 1'b0, 1'b0, 1, 0); step(); stop();
    drain();
    repeat (W + 4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
